// File: rtl/rom_sequencer_pkg.sv
// rom_sequencer_pkg: shared definitions for the ROM note sequencer.
//   state_t      - sequencer FSM state encoding
//   END_ALL_ONES - END marker source; each user slices its low DW bits
//   cnt_width()  - width of the note-duration counter for a given hold time
package rom_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   // A ROM word of all ones marks the end of the melody.
   localparam logic [63:0] END_ALL_ONES = '1;

   // clog2(dur)+1 bits always holds dur-1 with headroom, so the counter
   // cannot wrap while a note is held.
   function automatic int cnt_width(input int dur);
      return $clog2(dur) + 1;
   endfunction

endpackage

// File: rtl/rom_sequencer_if.sv
// rom_sequencer_if: control, ROM and note signals of the sequencer.
//   start, stop  - level requests toward the sequencer
//   addr         - ROM address from the sequencer (1-cycle-latency ROM)
//   rom_data     - ROM word for the address sampled one cycle earlier
//   note         - current note divisor (0 = silence)
//   note_strobe  - single-cycle pulse in the cycle note takes a new value
//   playing      - high while a melody is in progress
//   done         - single-cycle pulse on normal melody end
//   state_dbg    - current FSM state, for observation only
// Handshake: there is no back-pressure. start/stop are levels sampled at
// every clock edge; note_strobe acts as a valid qualifier for note and the
// consumer must accept the new note in the strobe cycle.
interface rom_sequencer_if #(
   parameter int AW = 5,
   parameter int DW = 16
);
   import rom_sequencer_pkg::*;

   logic          start;
   logic          stop;
   logic [AW-1:0] addr;
   logic [DW-1:0] rom_data;
   logic [DW-1:0] note;
   logic          note_strobe;
   logic          playing;
   logic          done;
   state_t        state_dbg;

   modport master (
      output start, stop, rom_data,
      input  addr, note, note_strobe, playing, done, state_dbg
   );

   modport slave (
      input  start, stop, rom_data,
      output addr, note, note_strobe, playing, done, state_dbg
   );

endinterface

// File: rtl/rom_sequencer_note_timer.sv
// note_timer: loadable up-counter that measures how long a note is held.
//   clk, rst - clock and synchronous active-high reset
//   load     - clear the count to zero (takes priority over en)
//   en       - count up by one; the count stops at the terminal value
//   tc       - high while the count equals TC
module note_timer #(
   parameter int W  = 2,
   parameter int TC = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam logic [W-1:0] TC_VAL = W'(TC);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (en && !tc) begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == TC_VAL);

endmodule

// File: rtl/rom_sequencer.sv
// rom_sequencer: steps through an external synchronous ROM of note divisors,
// holding each note for DUR cycles.
//   clk, rst - clock and synchronous active-high reset
//   bus      - rom_sequencer_if slave: start/stop in, ROM address/data,
//              note, note_strobe, playing, done and state_dbg out
// Each word costs ADDR (ROM samples addr) + DATA (word arrives) + DUR HOLD
// cycles. An all-ones word or the last address ends the melody, or restarts
// it at address 0 when LOOP=1.
module rom_sequencer
   import rom_sequencer_pkg::*;
#(
   parameter int AW   = 5,
   parameter int DW   = 16,
   parameter int DUR  = 3000000,
   parameter int LOOP = 0
) (
   input logic            clk,
   input logic            rst,
   rom_sequencer_if.slave bus
);

   localparam int            CW        = cnt_width(DUR);
   localparam logic [DW-1:0] END_WORD  = END_ALL_ONES[DW-1:0];
   localparam logic [AW-1:0] ADDR_LAST = '1;

   state_t        state;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] note_q;
   logic          strobe_q;
   logic          playing_q;
   logic          done_q;
   logic          hold_tc;

   // Restart the count as each word is latched; it only advances in HOLD.
   note_timer #(
      .W  (CW),
      .TC (DUR - 1)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (state == S_DATA),
      .en   (state == S_HOLD),
      .tc   (hold_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         note_q    <= '0;
         strobe_q  <= 1'b0;
         playing_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         if (state != S_IDLE && bus.stop) begin
            // Abort: silent and idle, with no done and no strobe.
            state     <= S_IDLE;
            addr_q    <= '0;
            note_q    <= '0;
            playing_q <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.start && !bus.stop) begin
                     addr_q    <= '0;
                     playing_q <= 1'b1;
                     state     <= S_ADDR;
                  end
               end
               S_ADDR: state <= S_DATA;
               S_DATA: begin
                  if (bus.rom_data == END_WORD) begin
                     addr_q <= '0;
                     if (LOOP != 0) begin
                        state <= S_ADDR;
                     end else begin
                        note_q    <= '0;
                        playing_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= S_IDLE;
                     end
                  end else begin
                     note_q   <= bus.rom_data;
                     strobe_q <= 1'b1;
                     state    <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (hold_tc) begin
                     if (addr_q != ADDR_LAST) begin
                        addr_q <= addr_q + AW'(1);
                        state  <= S_ADDR;
                     end else if (LOOP != 0) begin
                        addr_q <= '0;
                        state  <= S_ADDR;
                     end else begin
                        // Last word played: end without reading past it.
                        addr_q    <= '0;
                        note_q    <= '0;
                        playing_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= S_IDLE;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.addr        = addr_q;
   assign bus.note        = note_q;
   assign bus.note_strobe = strobe_q;
   assign bus.playing     = playing_q;
   assign bus.done        = done_q;
   assign bus.state_dbg   = state;

endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: bench for rom_sequencer with three instances
// (DUR=4 LOOP=0, DUR=4 LOOP=1, DUR=1 LOOP=0), all AW=2, sharing one ROM image.
// Expected per-cycle outputs come from a word-level timing model of the
// melody; index k is the state just after clock edge k of a run.
module tb_rom_sequencer;

   localparam int NMAX = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_d = 1'b0;
   logic stop_d = 1'b0;
   int   sel = 0;

   always #5 clk = ~clk;

   rom_sequencer_if #(.AW(2), .DW(16)) b0 ();
   rom_sequencer_if #(.AW(2), .DW(16)) b1 ();
   rom_sequencer_if #(.AW(2), .DW(16)) b2 ();

   rom_sequencer #(.AW(2), .DW(16), .DUR(4), .LOOP(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
   rom_sequencer #(.AW(2), .DW(16), .DUR(4), .LOOP(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
   rom_sequencer #(.AW(2), .DW(16), .DUR(1), .LOOP(0)) u2 (.clk(clk), .rst(rst), .bus(b2));

   assign b0.start = (sel == 0) && start_d;
   assign b1.start = (sel == 1) && start_d;
   assign b2.start = (sel == 2) && start_d;
   assign b0.stop  = (sel == 0) && stop_d;
   assign b1.stop  = (sel == 1) && stop_d;
   assign b2.stop  = (sel == 2) && stop_d;

   // External ROM with one cycle of read latency.
   logic [15:0] rom [4];
   always @(posedge clk) begin
      b0.rom_data <= rom[b0.addr];
      b1.rom_data <= rom[b1.addr];
      b2.rom_data <= rom[b2.addr];
   end

   // Observed outputs of the selected instance: {addr, note, strobe, playing, done}.
   logic [20:0] obs;
   always_comb begin
      case (sel)
         1:       obs = {b1.addr, b1.note, b1.note_strobe, b1.playing, b1.done};
         2:       obs = {b2.addr, b2.note, b2.note_strobe, b2.playing, b2.done};
         default: obs = {b0.addr, b0.note, b0.note_strobe, b0.playing, b0.done};
      endcase
   end

   int tests_run = 0;
   int tests_failed = 0;

   // Stimulus masks: signal high at edge k.
   bit start_m [NMAX];
   bit stop_m  [NMAX];
   bit rst_m   [NMAX];

   // Expected state after edge k.
   logic [15:0] exp_note   [NMAX];
   logic        exp_strobe [NMAX];
   logic        exp_play   [NMAX];
   logic        exp_done   [NMAX];
   logic [1:0]  exp_addr   [NMAX];
   bit          exp_achk   [NMAX];

   function automatic void clear_all(int n);
      for (int k = 0; k < n; k++) begin
         start_m[k] = 0; stop_m[k] = 0; rst_m[k] = 0;
         exp_note[k] = 16'h0; exp_strobe[k] = 0; exp_play[k] = 0;
         exp_done[k] = 0; exp_addr[k] = 2'd0; exp_achk[k] = 0;
      end
   endfunction

   // One melody accepted at edge base. Each word: two cycles to fetch (old
   // note kept), then dur cycles showing the new note. Returns the edge at
   // which the melody ends (done pulse), or n if it does not end in range.
   function automatic int build_model(int base, int dur, bit loop, int n);
      int t = base;
      int a = 0;
      logic [15:0] cur = 16'h0;
      while (t < n) begin
         for (int k = t; k < t + 2 && k < n; k++) begin
            exp_note[k] = cur; exp_play[k] = 1; exp_addr[k] = 2'(a); exp_achk[k] = 1;
         end
         if (rom[a] == 16'hFFFF) begin
            if (loop) begin
               a = 0; t = t + 2;
               continue;
            end
            if (t + 2 < n) exp_done[t + 2] = 1;
            return t + 2;
         end
         cur = rom[a];
         if (t + 2 < n) exp_strobe[t + 2] = 1;
         for (int k = t + 2; k < t + 2 + dur && k < n; k++) begin
            exp_note[k] = cur; exp_play[k] = 1; exp_addr[k] = 2'(a); exp_achk[k] = 1;
         end
         t = t + 2 + dur;
         if (a == 3) begin
            if (!loop) begin
               if (t < n) exp_done[t] = 1;
               return t;
            end
            a = 0;
         end else begin
            a = a + 1;
         end
      end
      return n;
   endfunction

   // Abort (stop or reset) at edge s: idle, silent, address 0 from then on.
   function automatic void apply_stop(int s, int n);
      for (int k = s; k < n; k++) begin
         exp_note[k] = 16'h0; exp_strobe[k] = 0; exp_play[k] = 0;
         exp_done[k] = 0; exp_addr[k] = 2'd0; exp_achk[k] = 1;
      end
   endfunction

   function automatic logic [15:0] rand_word();
      int r = $urandom_range(0, 5);
      if (r == 0) return 16'hFFFF;
      if (r == 1) return 16'h0000;
      return 16'($urandom_range(1, 16'hFFFE));
   endfunction

   task automatic test_reset();
      rst = 1; start_d = 1; stop_d = 0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({b0.addr, b0.note, b0.note_strobe, b0.playing, b0.done} !== 21'h0) begin
         tests_failed++; $display("FAIL reset_u0 got %h exp 0", {b0.addr, b0.note, b0.note_strobe, b0.playing, b0.done});
      end
      tests_run++;
      if ({b1.addr, b1.note, b1.note_strobe, b1.playing, b1.done} !== 21'h0) begin
         tests_failed++; $display("FAIL reset_u1 got %h exp 0", {b1.addr, b1.note, b1.note_strobe, b1.playing, b1.done});
      end
      tests_run++;
      if ({b2.addr, b2.note, b2.note_strobe, b2.playing, b2.done} !== 21'h0) begin
         tests_failed++; $display("FAIL reset_u2 got %h exp 0", {b2.addr, b2.note, b2.note_strobe, b2.playing, b2.done});
      end
      rst = 0; start_d = 0;
   endtask

   task automatic test_melody();
      int n = 26;
      sel = 0;
      rom[0] = 16'h0010; rom[1] = 16'h0020; rom[2] = 16'h0000; rom[3] = 16'hFFFF;
      clear_all(n);
      start_m[0] = 1;
      void'(build_model(0, 4, 0, n));
      for (int k = 0; k < n; k++) begin
         start_d = start_m[k]; stop_d = stop_m[k]; rst = rst_m[k];
         @(posedge clk); #1;
         tests_run++;
         if (obs[18:0] !== {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]}) begin
            tests_failed++; $display("FAIL melody k=%0d got %h exp %h", k, obs[18:0], {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]});
         end
         if (exp_achk[k]) begin
            tests_run++;
            if (obs[20:19] !== exp_addr[k]) begin
               tests_failed++; $display("FAIL melody_addr k=%0d got %0d exp %0d", k, obs[20:19], exp_addr[k]);
            end
         end
      end
      start_d = 0; rst = 0; stop_d = 1; repeat (2) @(posedge clk); #1; stop_d = 0;
   endtask

   task automatic test_loop();
      int n = 60;
      sel = 1;
      rom[0] = 16'h0010; rom[1] = 16'h0020; rom[2] = 16'h0000; rom[3] = 16'hFFFF;
      clear_all(n);
      start_m[0] = 1;
      void'(build_model(0, 4, 1, n));
      for (int k = 0; k < n; k++) begin
         start_d = start_m[k]; stop_d = stop_m[k]; rst = rst_m[k];
         @(posedge clk); #1;
         tests_run++;
         if (obs[18:0] !== {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]}) begin
            tests_failed++; $display("FAIL loop k=%0d got %h exp %h", k, obs[18:0], {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]});
         end
         if (exp_achk[k]) begin
            tests_run++;
            if (obs[20:19] !== exp_addr[k]) begin
               tests_failed++; $display("FAIL loop_addr k=%0d got %0d exp %0d", k, obs[20:19], exp_addr[k]);
            end
         end
      end
      start_d = 0; rst = 0; stop_d = 1; repeat (2) @(posedge clk); #1; stop_d = 0;
   endtask

   task automatic test_no_end();
      int n = 30;
      sel = 0;
      rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'h0003; rom[3] = 16'h0004;
      clear_all(n);
      start_m[0] = 1;
      void'(build_model(0, 4, 0, n));
      for (int k = 0; k < n; k++) begin
         start_d = start_m[k]; stop_d = stop_m[k]; rst = rst_m[k];
         @(posedge clk); #1;
         tests_run++;
         if (obs[18:0] !== {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]}) begin
            tests_failed++; $display("FAIL no_end k=%0d got %h exp %h", k, obs[18:0], {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]});
         end
         if (exp_achk[k]) begin
            tests_run++;
            if (obs[20:19] !== exp_addr[k]) begin
               tests_failed++; $display("FAIL no_end_addr k=%0d got %0d exp %0d", k, obs[20:19], exp_addr[k]);
            end
         end
      end
      start_d = 0; rst = 0; stop_d = 1; repeat (2) @(posedge clk); #1; stop_d = 0;
   endtask

   // Stop in the second HOLD cycle of 0x20 (note latched at edge 8, stop
   // sampled at edge 10), then start+stop together while idle.
   task automatic test_stop();
      int n = 22;
      sel = 0;
      rom[0] = 16'h0010; rom[1] = 16'h0020; rom[2] = 16'h0000; rom[3] = 16'hFFFF;
      clear_all(n);
      start_m[0] = 1; stop_m[10] = 1;
      void'(build_model(0, 4, 0, n));
      apply_stop(10, n);
      for (int k = 16; k < 22; k++) begin
         start_m[k] = 1; stop_m[k] = 1;
      end
      for (int k = 0; k < n; k++) begin
         start_d = start_m[k]; stop_d = stop_m[k]; rst = rst_m[k];
         @(posedge clk); #1;
         tests_run++;
         if (obs[18:0] !== {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]}) begin
            tests_failed++; $display("FAIL stop k=%0d got %h exp %h", k, obs[18:0], {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]});
         end
         if (exp_achk[k]) begin
            tests_run++;
            if (obs[20:19] !== exp_addr[k]) begin
               tests_failed++; $display("FAIL stop_addr k=%0d got %0d exp %0d", k, obs[20:19], exp_addr[k]);
            end
         end
      end
      start_d = 0; rst = 0; stop_d = 1; repeat (2) @(posedge clk); #1; stop_d = 0;
   endtask

   // Reset sampled at edge 2 (DATA of the first word), fresh start at edge 5.
   task automatic test_reset_mid();
      int n = 32;
      sel = 0;
      rom[0] = 16'h0010; rom[1] = 16'h0020; rom[2] = 16'h0000; rom[3] = 16'hFFFF;
      clear_all(n);
      start_m[0] = 1; rst_m[2] = 1; start_m[5] = 1;
      void'(build_model(0, 4, 0, n));
      apply_stop(2, n);
      void'(build_model(5, 4, 0, n));
      for (int k = 0; k < n; k++) begin
         start_d = start_m[k]; stop_d = stop_m[k]; rst = rst_m[k];
         @(posedge clk); #1;
         tests_run++;
         if (obs[18:0] !== {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]}) begin
            tests_failed++; $display("FAIL reset_mid k=%0d got %h exp %h", k, obs[18:0], {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]});
         end
         if (exp_achk[k]) begin
            tests_run++;
            if (obs[20:19] !== exp_addr[k]) begin
               tests_failed++; $display("FAIL reset_mid_addr k=%0d got %0d exp %0d", k, obs[20:19], exp_addr[k]);
            end
         end
      end
      start_d = 0; rst = 0; stop_d = 1; repeat (2) @(posedge clk); #1; stop_d = 0;
   endtask

   // DUR=1: notes every 3 cycles, one strobe per note.
   task automatic test_dur1();
      int n = 20;
      sel = 2;
      rom[0] = 16'h1234; rom[1] = 16'h0000; rom[2] = 16'(($urandom_range(1, 16'hFFFE)));
      rom[3] = 16'h00AB;
      clear_all(n);
      start_m[0] = 1;
      void'(build_model(0, 1, 0, n));
      for (int k = 0; k < n; k++) begin
         start_d = start_m[k]; stop_d = stop_m[k]; rst = rst_m[k];
         @(posedge clk); #1;
         tests_run++;
         if (obs[18:0] !== {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]}) begin
            tests_failed++; $display("FAIL dur1 k=%0d got %h exp %h", k, obs[18:0], {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]});
         end
         if (exp_achk[k]) begin
            tests_run++;
            if (obs[20:19] !== exp_addr[k]) begin
               tests_failed++; $display("FAIL dur1_addr k=%0d got %0d exp %0d", k, obs[20:19], exp_addr[k]);
            end
         end
      end
      start_d = 0; rst = 0; stop_d = 1; repeat (2) @(posedge clk); #1; stop_d = 0;
   endtask

   // start held high across the end restarts on the next idle cycle.
   task automatic test_restart();
      int n = 48;
      int e;
      sel = 0;
      rom[0] = 16'h0010; rom[1] = 16'h0020; rom[2] = 16'h0000; rom[3] = 16'hFFFF;
      clear_all(n);
      e = build_model(0, 4, 0, n);
      for (int k = 0; k <= e + 1; k++) start_m[k] = 1;
      void'(build_model(e + 1, 4, 0, n));
      for (int k = 0; k < n; k++) begin
         start_d = start_m[k]; stop_d = stop_m[k]; rst = rst_m[k];
         @(posedge clk); #1;
         tests_run++;
         if (obs[18:0] !== {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]}) begin
            tests_failed++; $display("FAIL restart k=%0d got %h exp %h", k, obs[18:0], {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]});
         end
         if (exp_achk[k]) begin
            tests_run++;
            if (obs[20:19] !== exp_addr[k]) begin
               tests_failed++; $display("FAIL restart_addr k=%0d got %0d exp %0d", k, obs[20:19], exp_addr[k]);
            end
         end
      end
      start_d = 0; rst = 0; stop_d = 1; repeat (2) @(posedge clk); #1; stop_d = 0;
   endtask

   // Random ROM images, instance, start edge and optional stop.
   task automatic test_random();
      int n = 40;
      for (int it = 0; it < 10; it++) begin
         int b, s, e, dur;
         bit lp;
         sel = $urandom_range(0, 2);
         dur = (sel == 2) ? 1 : 4;
         lp  = (sel == 1);
         for (int i = 0; i < 4; i++) rom[i] = rand_word();
         clear_all(n);
         b = $urandom_range(0, 3);
         start_m[b] = 1;
         e = build_model(b, dur, lp, n);
         if ($urandom_range(0, 1) == 1) begin
            s = b + $urandom_range(1, 30);
            if (s < n) begin
               stop_m[s] = 1;
               if (s <= e) apply_stop(s, n);
            end
         end
         for (int k = 0; k < n; k++) begin
            start_d = start_m[k]; stop_d = stop_m[k]; rst = rst_m[k];
            @(posedge clk); #1;
            tests_run++;
            if (obs[18:0] !== {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]}) begin
               tests_failed++; $display("FAIL random it=%0d sel=%0d k=%0d got %h exp %h", it, sel, k, obs[18:0], {exp_note[k], exp_strobe[k], exp_play[k], exp_done[k]});
            end
            if (exp_achk[k]) begin
               tests_run++;
               if (obs[20:19] !== exp_addr[k]) begin
                  tests_failed++; $display("FAIL random_addr it=%0d sel=%0d k=%0d got %0d exp %0d", it, sel, k, obs[20:19], exp_addr[k]);
               end
            end
         end
         start_d = 0; rst = 0; stop_d = 1; repeat (2) @(posedge clk); #1; stop_d = 0;
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) rom[i] = 16'h0;
      test_reset();
      test_melody();
      test_loop();
      test_no_end();
      test_stop();
      test_reset_mid();
      test_dur1();
      test_restart();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/rom_sequencer.md
ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 Parameter AW, default 5: ROM address width; ROM depth is 2**AW.
REQ-002 Parameter DW, default 16: ROM data width, one note divisor per word.
REQ-003 Parameter DUR, default 3000000: note hold time in clk cycles; legal range DUR >= 1.
REQ-004 Parameter LOOP, default 0: 1 restarts the melody at address 0, 0 stops at melody end.
REQ-005 clk  in  1  system clock; all logic on posedge clk.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  level; sampled only in IDLE; begins playback at address 0.
REQ-008 stop  in  1  level; aborts playback from any non-IDLE state.
REQ-009 addr  out  AW  registered ROM address, driven to a 1-cycle-latency synchronous ROM.
REQ-010 rom_data  in  DW  ROM output; valid the cycle after addr is sampled by the ROM.
REQ-011 note  out  DW  registered current note divisor (0 = rest/silence).
REQ-012 note_strobe  out  1  one-cycle pulse in the cycle note takes a new value.
REQ-013 playing  out  1  high from start acceptance until end or stop.
REQ-014 done  out  1  one-cycle pulse on normal melody end (LOOP=0 only).

Function
REQ-015 FSM states: IDLE, ADDR, DATA, HOLD; encoding per shared package.
REQ-016 IDLE: start=1 and stop=0 -> addr<=0, playing<=1, go ADDR.
REQ-017 ADDR: one cycle while the ROM samples addr; go DATA.
REQ-018 DATA: rom_data all ones (END marker) -> end handling per REQ-022; otherwise note<=rom_data, note_strobe=1 next cycle, duration counter<=0, go HOLD.
REQ-019 HOLD: counter increments each cycle; at counter==DUR-1, go ADDR with addr<=addr+1 (modulo 2**AW).
REQ-020 Timing: start sampled at edge E0 -> first note visible after E2; subsequent notes change every DUR+2 cycles; note holds its previous value during ADDR and DATA.
REQ-021 Address wrap: leaving HOLD at addr==2**AW-1 with LOOP=1 -> addr<=0; with LOOP=0 -> end handling, no ROM read beyond the last word.
REQ-022 End handling: LOOP=1 -> addr<=0, go ADDR, playing stays 1, no done; LOOP=0 -> note<=0, playing<=0, done=1 for one cycle, go IDLE.
REQ-023 Rest word 0x0 is latched as a normal note, with strobe and full DUR hold.
REQ-024 stop=1 in ADDR/DATA/HOLD -> next cycle IDLE, note=0, playing=0, addr=0, no done, no strobe.
REQ-025 stop and start both high in IDLE: stop wins, remain IDLE.
REQ-026 start while playing is ignored; start held high after end restarts playback on the next IDLE cycle.
REQ-027 Counter width is clog2(DUR)+1 bits; it never wraps within HOLD.

Reset
REQ-028 rst=1 at a clock edge -> state IDLE, addr=0, note=0, note_strobe=0, playing=0, done=0, counter=0, from any state.
REQ-029 rst overrides start and stop; reset mid-note produces no done and no strobe.

Structure
REQ-030 Shared package holds the state enum, END marker constant (all ones of DW), and counter-width function.
REQ-031 One sub-module, note_timer: loadable up-counter with terminal-count output, instantiated with width from the package.
REQ-032 The ROM is external; rom_sequencer contains no memory array.

Verification
REQ-033 AW=2, DUR=4, LOOP=0, ROM {0x0010,0x0020,0x0000,0xFFFF}; start pulse -> note 0x10, 0x20, 0x00 each held 6 cycles apart, then done pulse, note=0, playing=0.
REQ-034 Same ROM, LOOP=1 -> sequence 0x10,0x20,0x00 repeats at least twice; done never asserts; playing stays 1.
REQ-035 ROM {1,2,3,4} with no END marker, LOOP=0 -> four notes, addr never exceeds 3, done after the fourth hold.
REQ-036 stop asserted during the 2nd cycle of HOLD for 0x20 -> IDLE next cycle, note=0, no done; start and stop together in IDLE -> no playback.
REQ-037 rst asserted during DATA -> all outputs 0 next cycle; subsequent start replays from 0x10 with the REQ-020 timing.
REQ-038 DUR=1 -> notes change every 3 cycles; note_strobe exactly one cycle per note.
